// File: rtl/rsa_modexp_param_pkg.sv
// Shared definitions for the parametrised RSA modular-exponentiation engine:
// FSM state encoding and the width rule for the per-multiplication bit counter.
package rsa_modexp_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_MUL   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Width of a counter that must hold the values 0..width inclusive.
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/rsa_modexp_param_if.sv
// Request/result bundle of the modexp engine. The master drives the operands
// and the start request; the slave (the engine) returns the result and status.
interface rsa_modexp_param_if #(
  parameter int WIDTH     = 128,
  parameter int EXP_WIDTH = WIDTH
);
  logic                 start;
  logic [WIDTH-1:0]     message;
  logic [EXP_WIDTH-1:0] e_key;
  logic [WIDTH-1:0]     n;
  logic [WIDTH-1:0]     c;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (output start, message, e_key, n, input c, busy, done, err);
  modport slave  (input start, message, e_key, n, output c, busy, done, err);
endinterface

// File: rtl/rsa_modexp_param_mod_mul.sv
// Interleaved modular multiplier: acc = a*b mod n, scanning b MSB-first,
// one bit per cycle. load captures the operands; WIDTH steps follow, and
// valid is high for the single cycle after the last step. Operands must be < n.
module rsa_modexp_param_mod_mul
  import rsa_modexp_param_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] acc,
  output logic             valid
);
  localparam int CW = cnt_bits(WIDTH);

  logic [WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d, n_q, n_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  // acc < n, so 2*acc + a < 3n fits in WIDTH+2 bits; two conditional
  // subtractions bring it back below n.
  logic [WIDTH+1:0] n_ext, t_dbl, t_add, t_sub1;
  logic [WIDTH-1:0] t_sub2;

  // One multiplier step per cycle while the bit counter is non-zero.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and no latch is inferred.
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    n_ext   = {2'b00, n_q};
    t_dbl   = {1'b0, acc_q, 1'b0};
    t_add   = b_q[WIDTH-1] ? t_dbl + {2'b00, a_q} : t_dbl;
    t_sub1  = (t_add >= n_ext) ? t_add - n_ext : t_add;
    t_sub2  = WIDTH'((t_sub1 >= n_ext) ? t_sub1 - n_ext : t_sub1);
    if (load) begin
      acc_d = '0;
      a_d   = a;
      b_d   = b;
      n_d   = n;
      cnt_d = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_d   = t_sub2;
      b_d     = b_q << 1;
      cnt_d   = cnt_q - CW'(1);
      valid_d = (cnt_q == CW'(1));
    end
  end

  // Multiplier registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign acc   = acc_q;
  assign valid = valid_q;

endmodule

// File: rtl/rsa_modexp_param.sv
// RSA modular exponentiation c = message^e_key mod n, right-to-left binary
// method. Each exponent bit costs WIDTH multiply cycles (square and multiply
// run in parallel) plus one commit cycle. One operation in flight at a time.
module rsa_modexp_param
  import rsa_modexp_param_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter int EXP_WIDTH = WIDTH
) (
  input logic               clk,
  input logic               reset,
  rsa_modexp_param_if.slave bus
);
  localparam int CW = cnt_bits(WIDTH);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     msg_q, msg_d, n_q, n_d, r_q, r_d, b_q, b_d, c_q, c_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 load;
  logic [WIDTH-1:0]     sq_acc, mul_acc;
  logic                 sq_valid, mul_valid;

  // Operands are loaded from the next-state r/b values, so the multipliers
  // start on the freshly committed values during the first MUL cycle.
  rsa_modexp_param_mod_mul #(.WIDTH(WIDTH)) u_square (
    .clk(clk), .reset(reset), .load(load),
    .a(b_d), .b(b_d), .n(n_q), .acc(sq_acc), .valid(sq_valid)
  );

  rsa_modexp_param_mod_mul #(.WIDTH(WIDTH)) u_multiply (
    .clk(clk), .reset(reset), .load(load),
    .a(r_d), .b(b_d), .n(n_q), .acc(mul_acc), .valid(mul_valid)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    n_d     = n_q;
    e_d     = e_q;
    r_d     = r_q;
    b_d     = b_q;
    c_d     = c_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          msg_d   = bus.message;
          e_d     = bus.e_key;
          n_d     = bus.n;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (n_q < WIDTH'(2) || msg_q >= n_q) begin
          err_d   = 1'b1;
          c_d     = '0;
          state_d = ST_DONE;
        end else if (e_q == '0) begin
          // 0^0 is defined as 1, matching any other base.
          err_d   = 1'b0;
          c_d     = WIDTH'(1);
          state_d = ST_DONE;
        end else begin
          err_d   = 1'b0;
          r_d     = WIDTH'(1);
          b_d     = msg_q;
          cnt_d   = '0;
          load    = 1'b1;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (e_q[0] && mul_valid) r_d = mul_acc;
        if (sq_valid)            b_d = sq_acc;
        e_d = e_q >> 1;
        if (e_d == '0) begin
          c_d     = r_d;
          state_d = ST_DONE;
        end else begin
          cnt_d   = '0;
          load    = 1'b1;
          state_d = ST_MUL;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      msg_q   <= '0;
      n_q     <= '0;
      e_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      n_q     <= n_d;
      e_q     <= e_d;
      r_q     <= r_d;
      b_q     <= b_d;
      c_q     <= c_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.c    = c_q;
  assign bus.err  = err_q;
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);

endmodule
